fetch_predecoder: RTL and testbench
===================================

// Module: fetch_predecoder
// PURPOSE
// - Instruction-fetch front end of the instruction queue stage.
// - Requests 32-bit words from the icache, predecodes jal/jalr/branch, and predicts the next PC.
//   Prediction uses a 2-bit BHT and the return-address call stack.
// - Enqueues {inst, pc, pred_taken, pred_pc} into the instruction queue.
// - Drives the call_stack push/pop port and consumes its top output.
// PARAMETERS
// - ADDR_W    17  byte-address width (all PCs, modulo 2^ADDR_W)
// - BHT_BITS  6   log2 of BHT entries, indexed by pc[BHT_BITS+1:2]
// - RESET_PC  0   PC after reset
// PORTS
// - clk            in   1       clock, rising edge
// - rst            in   1       synchronous, active-high reset
// - ic_req_valid   out  1       icache request, held until ic_resp_valid
// - ic_req_addr    out  ADDR_W  word address requested (= pc)
// - ic_resp_valid  in   1       one-cycle pulse, data valid
// - ic_resp_inst   in   32      fetched instruction
// - iq_full        in   1       instruction queue cannot accept this cycle
// - iq_push        out  1       enqueue strobe
// - iq_inst        out  32      instruction
// - iq_pc          out  ADDR_W  its PC
// - iq_pred_taken  out  1       predicted taken (jal, ret, BHT-taken branch)
// - iq_pred_pc     out  ADDR_W  predicted next PC
// - flush_en       in   1       mispredict redirect from commit
// - flush_pc       in   ADDR_W  redirect target
// - bp_upd_en      in   1       BHT training strobe
// - bp_upd_pc      in   ADDR_W  PC of resolved branch
// - bp_upd_taken   in   1       resolved direction
// - rs_en          out  1       call_stack operation strobe
// - rs_push_mode   out  1       1 = push, 0 = pop
// - rs_push_addr   out  ADDR_W  return address pushed (pc+4)
// - rs_top         in   ADDR_W  call_stack top
// BEHAVIOUR
// - FSM states: S_REQ, S_WAIT, S_DEC, S_ISSUE.
//   - S_REQ: ic_req_valid=1, addr=pc; next state S_WAIT.
//   - S_WAIT: hold request. On ic_resp_valid, latch inst and go to S_DEC.
//   - S_DEC: classify, compute pred, latch. rs_en=0 here, so rs_top is read unperturbed.
//   - S_ISSUE: if !iq_full, then iq_push=1, fire the stack op, pc<=pred_pc, go to S_REQ. Else stall with outputs held.
// - Reset: state=S_REQ, pc=RESET_PC, discard=0; all outputs 0.
//   BHT counters reset to 2'b01 (weakly not taken).
// - Classification (opcode[6:0], rd, rs1, imm):
//   - jal: taken, target pc+immJ. Push pc+4 if rd in {x1,x5}.
//   - jalr, ret form (rd=x0, rs1 in {x1,x5}, imm=0): taken, target rs_top, pop.
//   - jalr, rd in {x1,x5}, not ret form: not taken, pred pc+4, push pc+4.
//   - other jalr: not taken, pc+4.
//   - branch: taken iff BHT[idx][1]; target pc+immB, else pc+4.
//   - anything else: not taken, pc+4.
// - Arithmetic: imm sign-extended, sums truncated to ADDR_W bits (wrap at 2^ADDR_W).
// - Stack op fires only in the S_ISSUE push cycle; at most one op per instruction.
// - flush_en has priority over everything in any state:
//   - pc<=flush_pc, state<=S_REQ; no iq_push or rs_en that cycle.
//   - If flushed in S_WAIT or S_REQ, set discard. The next ic_resp_valid is dropped and discard cleared.
//   - A resp in the same cycle as the flush is dropped, and discard is not set for it.
// - Request after a flush is issued the next cycle; a discarded request must complete before any new resp is accepted.
// - BHT update: saturating +/-1 at bp_upd_pc index, effective the next cycle.
//   A same-cycle read of the same index sees the old value.
// - Throughput: 1 instr per 4 cycles minimum (no overlap).
// STRUCTURE
// - Package fetch_pkg: opcode constants (OP_JAL, OP_JALR, OP_BRANCH), link-register test function, state enum.
// - Sub-module bht_2bit (2^BHT_BITS x 2-bit, one combinational read, one synchronous update).
// - call_stack stays external; connected at the instruction-queue level.
// TESTING
// - Reset, then icache returns addi at 0x0: iq_push with pc=0, pred_pc=4, pred_taken=0; next ic_req_addr=4.
// - jal x1,+0x40 at 0x100: pred_pc=0x140, taken=1; rs_en=1, push_mode=1, push_addr=0x104 in the push cycle.
// - ret at 0x200 with rs_top=0x104: pred_pc=0x104, taken=1, rs_en=1, push_mode=0.
// - beq at 0x10, imm=-16: BHT reset -> pred 0x14. Two updates taken -> next fetch preds 0x0.
// - flush_en(pc=0x300) in S_WAIT: late resp dropped, no iq_push; next ic_req_addr=0x300.
// - iq_full held 5 cycles in S_ISSUE: no push, outputs stable, no rs_en; push the cycle iq_full drops.
//   jal at 0x1FFFC, imm=+8: pred_pc wraps to 0x4.

Source files
------------

// File: rtl/fetch_predecoder_pkg.sv
// Shared definitions for the fetch predecoder: RISC-V control-flow opcodes,
// the fetch FSM state type and immediate/link-register helpers.
package fetch_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DEC,
    S_ISSUE
  } fetch_state_e;

  // x1 (ra) and x5 (t0) are the architectural link registers.
  function automatic logic isLinkReg(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic logic [31:0] immJ(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] immB(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters: one combinational read
// port and one synchronous training port; a same-cycle read sees the old value.
module bht_2bit #(
  parameter int BHT_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BHT_BITS-1:0] rd_idx_i,
  output logic                rd_taken_o,
  input  logic                upd_en_i,
  input  logic [BHT_BITS-1:0] upd_idx_i,
  input  logic                upd_taken_i
);

  localparam int ENTRIES = 1 << BHT_BITS;

  logic [1:0] ctr_q [ENTRIES];
  logic [1:0] updCtr;
  logic [1:0] updCtr_d;

  assign rd_taken_o = ctr_q[rd_idx_i][1];
  assign updCtr     = ctr_q[upd_idx_i];

  always_comb begin
    updCtr_d = updCtr;
    if (upd_taken_i && (updCtr != 2'b11)) begin
      updCtr_d = updCtr + 2'b01;
    end else if (!upd_taken_i && (updCtr != 2'b00)) begin
      updCtr_d = updCtr - 2'b01;
    end
  end

  // Every counter starts weakly not-taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else if (upd_en_i) begin
      ctr_q[upd_idx_i] <= updCtr_d;
    end
  end

endmodule

// File: rtl/fetch_predecoder.sv
// Fetch front end: one instruction at a time through request, wait, predecode
// and issue, predicting the next PC from jal/jalr/branch, the BHT and the call stack.
module fetch_predecoder
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 17,
  parameter int                BHT_BITS = 6,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ic_req_valid,
  output logic [ADDR_W-1:0] ic_req_addr,
  input  logic              ic_resp_valid,
  input  logic [31:0]       ic_resp_inst,
  input  logic              iq_full,
  output logic              iq_push,
  output logic [31:0]       iq_inst,
  output logic [ADDR_W-1:0] iq_pc,
  output logic              iq_pred_taken,
  output logic [ADDR_W-1:0] iq_pred_pc,
  input  logic              flush_en,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              bp_upd_en,
  input  logic [ADDR_W-1:0] bp_upd_pc,
  input  logic              bp_upd_taken,
  output logic              rs_en,
  output logic              rs_push_mode,
  output logic [ADDR_W-1:0] rs_push_addr,
  input  logic [ADDR_W-1:0] rs_top
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              discard_q;
  logic              reqValid_q;
  logic [ADDR_W-1:0] reqAddr_q;
  logic [31:0]       inst_q;
  logic [ADDR_W-1:0] iqPc_q;
  logic              predTaken_q;
  logic [ADDR_W-1:0] predPc_q;
  logic              rsActive_q;
  logic              pushMode_q;
  logic [ADDR_W-1:0] pushAddr_q;

  logic              decTaken_d;
  logic [ADDR_W-1:0] decPred_d;
  logic              decRsEn_d;
  logic              decPush_d;

  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic              isRet;
  logic [ADDR_W-1:0] seqPc;
  logic [ADDR_W-1:0] jalTgt;
  logic [ADDR_W-1:0] brTgt;
  logic              bhtTaken;
  logic              issueFire;
  logic              unusedUpdBits;

  assign unusedUpdBits = ^{bp_upd_pc[ADDR_W-1:BHT_BITS+2], bp_upd_pc[1:0]};

  bht_2bit #(
    .BHT_BITS (BHT_BITS)
  ) u_bht (
    .clk         (clk),
    .rst         (rst),
    .rd_idx_i    (pc_q[BHT_BITS+1:2]),
    .rd_taken_o  (bhtTaken),
    .upd_en_i    (bp_upd_en),
    .upd_idx_i   (bp_upd_pc[BHT_BITS+1:2]),
    .upd_taken_i (bp_upd_taken)
  );

  assign opcode = inst_q[6:0];
  assign rd     = inst_q[11:7];
  assign rs1    = inst_q[19:15];
  assign isRet  = (rd == 5'd0) && isLinkReg(rs1) && (inst_q[31:20] == 12'd0);
  assign seqPc  = pc_q + ADDR_W'(4);
  assign jalTgt = pc_q + ADDR_W'(immJ(inst_q));
  assign brTgt  = pc_q + ADDR_W'(immB(inst_q));

  always_comb begin
    decTaken_d = 1'b0;
    decPred_d  = seqPc;
    decRsEn_d  = 1'b0;
    decPush_d  = 1'b0;
    case (opcode)
      OP_JAL: begin
        decTaken_d = 1'b1;
        decPred_d  = jalTgt;
        if (isLinkReg(rd)) begin
          decRsEn_d = 1'b1;
          decPush_d = 1'b1;
        end
      end
      OP_JALR: begin
        if (isRet) begin
          decTaken_d = 1'b1;
          decPred_d  = rs_top;
          decRsEn_d  = 1'b1;
        end else if (isLinkReg(rd)) begin
          decRsEn_d = 1'b1;
          decPush_d = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (bhtTaken) begin
          decTaken_d = 1'b1;
          decPred_d  = brTgt;
        end
      end
      default: ;
    endcase
  end

  // The enqueue strobe must react to iq_full in the same cycle, so it is the
  // only combinational output; the stack op rides on it.
  assign issueFire     = (state_q == S_ISSUE) && !iq_full && !flush_en && !rst;
  assign iq_push       = issueFire;
  assign rs_en         = issueFire && rsActive_q;
  assign ic_req_valid  = reqValid_q;
  assign ic_req_addr   = reqAddr_q;
  assign iq_inst       = inst_q;
  assign iq_pc         = iqPc_q;
  assign iq_pred_taken = predTaken_q;
  assign iq_pred_pc    = predPc_q;
  assign rs_push_mode  = pushMode_q;
  assign rs_push_addr  = pushAddr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      discard_q   <= 1'b0;
      reqValid_q  <= 1'b0;
      reqAddr_q   <= '0;
      inst_q      <= '0;
      iqPc_q      <= '0;
      predTaken_q <= 1'b0;
      predPc_q    <= '0;
      rsActive_q  <= 1'b0;
      pushMode_q  <= 1'b0;
      pushAddr_q  <= '0;
    end else if (flush_en) begin
      // An outstanding request will still answer once; drop that answer,
      // unless it is arriving right now and is already being ignored.
      state_q    <= S_REQ;
      pc_q       <= flush_pc;
      reqValid_q <= 1'b1;
      reqAddr_q  <= flush_pc;
      discard_q  <= reqValid_q && !ic_resp_valid;
    end else begin
      case (state_q)
        S_REQ: begin
          reqValid_q <= 1'b1;
          reqAddr_q  <= pc_q;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (ic_resp_valid) begin
            if (discard_q) begin
              discard_q <= 1'b0;
            end else begin
              inst_q     <= ic_resp_inst;
              reqValid_q <= 1'b0;
              state_q    <= S_DEC;
            end
          end
        end
        S_DEC: begin
          iqPc_q      <= pc_q;
          predTaken_q <= decTaken_d;
          predPc_q    <= decPred_d;
          rsActive_q  <= decRsEn_d;
          pushMode_q  <= decPush_d;
          pushAddr_q  <= seqPc;
          state_q     <= S_ISSUE;
        end
        S_ISSUE: begin
          if (!iq_full) begin
            pc_q       <= predPc_q;
            reqValid_q <= 1'b1;
            reqAddr_q  <= predPc_q;
            state_q    <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_predecoder.sv
// Directed bench for fetch_predecoder: an icache model with programmable latency,
// a vector table of predecode cases and hand-written flush/stall sequences.
module tb_fetch_predecoder;

   localparam int ADDR_W = 17;

   logic              clk;
   logic              rst;
   logic              ic_req_valid;
   logic [ADDR_W-1:0] ic_req_addr;
   logic              ic_resp_valid;
   logic [31:0]       ic_resp_inst;
   logic              iq_full;
   logic              iq_push;
   logic [31:0]       iq_inst;
   logic [ADDR_W-1:0] iq_pc;
   logic              iq_pred_taken;
   logic [ADDR_W-1:0] iq_pred_pc;
   logic              flush_en;
   logic [ADDR_W-1:0] flush_pc;
   logic              bp_upd_en;
   logic [ADDR_W-1:0] bp_upd_pc;
   logic              bp_upd_taken;
   logic              rs_en;
   logic              rs_push_mode;
   logic [ADDR_W-1:0] rs_push_addr;
   logic [ADDR_W-1:0] rs_top;

   int checks = 0;
   int errors = 0;

   logic [31:0]       imem [logic [ADDR_W-1:0]];
   int                icLat = 1;
   bit                icBusy = 1'b0;
   int                icCnt = 0;
   logic [ADDR_W-1:0] icAddr = '0;

   typedef struct {
      logic [ADDR_W-1:0] pc;
      logic [31:0]       inst;
      logic [ADDR_W-1:0] rsTop;
      int                nUpd;
      logic              updTaken;
      logic              expTaken;
      logic [ADDR_W-1:0] expPred;
      logic              expRsEn;
      logic              expMode;
      logic [ADDR_W-1:0] expPushAddr;
   } vec_t;

   localparam int NVEC = 10;
   vec_t vecs [NVEC];

   fetch_predecoder #(
      .ADDR_W   (ADDR_W),
      .BHT_BITS (6),
      .RESET_PC (17'h0)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ic_req_valid  (ic_req_valid),
      .ic_req_addr   (ic_req_addr),
      .ic_resp_valid (ic_resp_valid),
      .ic_resp_inst  (ic_resp_inst),
      .iq_full       (iq_full),
      .iq_push       (iq_push),
      .iq_inst       (iq_inst),
      .iq_pc         (iq_pc),
      .iq_pred_taken (iq_pred_taken),
      .iq_pred_pc    (iq_pred_pc),
      .flush_en      (flush_en),
      .flush_pc      (flush_pc),
      .bp_upd_en     (bp_upd_en),
      .bp_upd_pc     (bp_upd_pc),
      .bp_upd_taken  (bp_upd_taken),
      .rs_en         (rs_en),
      .rs_push_mode  (rs_push_mode),
      .rs_push_addr  (rs_push_addr),
      .rs_top        (rs_top)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] memRead(input logic [ADDR_W-1:0] a);
      if (imem.exists(a)) return imem[a];
      return 32'h00000013;
   endfunction

   // Icache model: picks up a visible request, answers icLat+1 negedges later
   // with a one-cycle pulse, then takes the next request if one is still held.
   always @(negedge clk) begin
      if (rst) begin
         ic_resp_valid = 1'b0;
         icBusy = 1'b0;
      end else begin
         ic_resp_valid = 1'b0;
         if (icBusy) begin
            if (icCnt == 0) begin
               ic_resp_valid = 1'b1;
               ic_resp_inst = memRead(icAddr);
               icBusy = 1'b0;
            end else begin
               icCnt = icCnt - 1;
            end
         end else if (ic_req_valid) begin
            icBusy = 1'b1;
            icAddr = ic_req_addr;
            icCnt = icLat;
         end
      end
   end

   // Safety net against a DUT that never makes progress.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic waitPush(input int limit, output int cycles);
      bit seen;
      seen = 1'b0;
      cycles = 0;
      while (!seen && cycles < limit) begin
         @(negedge clk);
         cycles++;
         if (iq_push) seen = 1'b1;
      end
      checkOutput("push_seen", {31'd0, seen}, 32'd1);
   endtask

   task automatic doFlush(input logic [ADDR_W-1:0] target);
      @(negedge clk);
      flush_en = 1'b1;
      flush_pc = target;
      @(negedge clk);
      flush_en = 1'b0;
   endtask

   task automatic applyStimulus(input int idx);
      vec_t v;
      int   cyc;
      string tag;
      v = vecs[idx];
      tag = $sformatf("v%0d", idx);
      imem[v.pc] = v.inst;
      rs_top = v.rsTop;
      for (int u = 0; u < v.nUpd; u++) begin
         @(negedge clk);
         bp_upd_en = 1'b1;
         bp_upd_pc = v.pc;
         bp_upd_taken = v.updTaken;
      end
      @(negedge clk);
      bp_upd_en = 1'b0;
      doFlush(v.pc);
      waitPush(40, cyc);
      checkOutput({tag, "_iq_pc"}, 32'(iq_pc), 32'(v.pc));
      checkOutput({tag, "_iq_inst"}, iq_inst, v.inst);
      checkOutput({tag, "_pred_taken"}, 32'(iq_pred_taken), 32'(v.expTaken));
      checkOutput({tag, "_pred_pc"}, 32'(iq_pred_pc), 32'(v.expPred));
      checkOutput({tag, "_rs_en"}, 32'(rs_en), 32'(v.expRsEn));
      if (v.expRsEn) checkOutput({tag, "_rs_mode"}, 32'(rs_push_mode), 32'(v.expMode));
      if (v.expRsEn && v.expMode) checkOutput({tag, "_rs_addr"}, 32'(rs_push_addr), 32'(v.expPushAddr));
   endtask

   initial begin
      int cyc;
      int n;

      //          pc        inst          rsTop     nUpd upd   taken pred      rsEn mode pushAddr
      vecs[0] = '{17'h00100, 32'h040000EF, 17'h0,    0, 1'b0, 1'b1, 17'h00140, 1'b1, 1'b1, 17'h00104};
      vecs[1] = '{17'h00200, 32'h00008067, 17'h0104, 0, 1'b0, 1'b1, 17'h00104, 1'b1, 1'b0, 17'h0};
      vecs[2] = '{17'h00300, 32'h000280E7, 17'h0AA0, 0, 1'b0, 1'b0, 17'h00304, 1'b1, 1'b1, 17'h00304};
      vecs[3] = '{17'h00040, 32'h00408067, 17'h0104, 0, 1'b0, 1'b0, 17'h00044, 1'b0, 1'b0, 17'h0};
      vecs[4] = '{17'h00080, 32'hFF9FF06F, 17'h0,    0, 1'b0, 1'b1, 17'h00078, 1'b0, 1'b0, 17'h0};
      vecs[5] = '{17'h00020, 32'h000012B7, 17'h0,    0, 1'b0, 1'b0, 17'h00024, 1'b0, 1'b0, 17'h0};
      vecs[6] = '{17'h00010, 32'hFE0008E3, 17'h0,    0, 1'b0, 1'b0, 17'h00014, 1'b0, 1'b0, 17'h0};
      vecs[7] = '{17'h00010, 32'hFE0008E3, 17'h0,    3, 1'b1, 1'b1, 17'h00000, 1'b0, 1'b0, 17'h0};
      vecs[8] = '{17'h00010, 32'hFE0008E3, 17'h0,    2, 1'b0, 1'b0, 17'h00014, 1'b0, 1'b0, 17'h0};
      vecs[9] = '{17'h01000, 32'h00028067, 17'h1ABCD, 0, 1'b0, 1'b1, 17'h1ABCD, 1'b1, 1'b0, 17'h0};

      rst = 1'b1;
      iq_full = 1'b0;
      flush_en = 1'b0;
      flush_pc = '0;
      bp_upd_en = 1'b0;
      bp_upd_pc = '0;
      bp_upd_taken = 1'b0;
      rs_top = '0;
      imem[17'h0] = 32'h00100093;

      // Reset values, then the first fetch from address 0.
      repeat (3) @(negedge clk);
      checkOutput("rst_req_valid", 32'(ic_req_valid), 32'd0);
      checkOutput("rst_req_addr", 32'(ic_req_addr), 32'd0);
      checkOutput("rst_iq_push", 32'(iq_push), 32'd0);
      checkOutput("rst_rs_en", 32'(rs_en), 32'd0);
      checkOutput("rst_pred_pc", 32'(iq_pred_pc), 32'd0);
      checkOutput("rst_pred_taken", 32'(iq_pred_taken), 32'd0);
      rst = 1'b0;
      waitPush(40, cyc);
      checkOutput("first_iq_pc", 32'(iq_pc), 32'h0);
      checkOutput("first_iq_inst", iq_inst, 32'h00100093);
      checkOutput("first_pred_pc", 32'(iq_pred_pc), 32'h4);
      checkOutput("first_pred_taken", 32'(iq_pred_taken), 32'd0);
      checkOutput("first_rs_en", 32'(rs_en), 32'd0);
      @(negedge clk);
      checkOutput("first_next_addr", 32'(ic_req_addr), 32'h4);
      checkOutput("first_next_valid", 32'(ic_req_valid), 32'd1);

      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(i);
      end

      // Flush while a slow request is outstanding: its late answer must be dropped.
      imem[17'h00400] = 32'h040000EF;
      imem[17'h00300] = 32'h000012B7;
      icLat = 6;
      doFlush(17'h00400);
      n = 0;
      while (!(icBusy && icAddr == 17'h00400) && n < 60) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput("wflush_req_seen", 32'(icAddr), 32'h00400);
      repeat (2) @(negedge clk);
      flush_en = 1'b1;
      flush_pc = 17'h00300;
      @(negedge clk);
      flush_en = 1'b0;
      checkOutput("wflush_next_addr", 32'(ic_req_addr), 32'h00300);
      checkOutput("wflush_next_valid", 32'(ic_req_valid), 32'd1);
      waitPush(80, cyc);
      checkOutput("wflush_iq_pc", 32'(iq_pc), 32'h00300);
      checkOutput("wflush_iq_inst", iq_inst, 32'h000012B7);
      checkOutput("wflush_pred_pc", 32'(iq_pred_pc), 32'h00304);
      icLat = 1;

      // Flush landing on the response cycle: response ignored, no discard armed.
      imem[17'h00500] = 32'h02A00513;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!ic_resp_valid && n < 20);
      checkOutput("sflush_resp_seen", 32'(ic_resp_valid), 32'd1);
      flush_en = 1'b1;
      flush_pc = 17'h00500;
      @(negedge clk);
      flush_en = 1'b0;
      waitPush(40, cyc);
      checkOutput("sflush_latency", 32'(cyc), 32'd4);
      checkOutput("sflush_iq_pc", 32'(iq_pc), 32'h00500);
      checkOutput("sflush_iq_inst", iq_inst, 32'h02A00513);

      // Queue full for five issue cycles, with a jal whose target wraps.
      imem[17'h1FFFC] = 32'h008002EF;
      @(negedge clk);
      iq_full = 1'b1;
      flush_en = 1'b1;
      flush_pc = 17'h1FFFC;
      @(negedge clk);
      flush_en = 1'b0;
      n = 0;
      while (iq_pc != 17'h1FFFC && n < 40) begin
         @(negedge clk);
         n++;
      end
      checkOutput("stall_reach", 32'(iq_pc), 32'h1FFFC);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         checkOutput($sformatf("stall%0d_iq_push", k), 32'(iq_push), 32'd0);
         checkOutput($sformatf("stall%0d_rs_en", k), 32'(rs_en), 32'd0);
         checkOutput($sformatf("stall%0d_pred_pc", k), 32'(iq_pred_pc), 32'h4);
         checkOutput($sformatf("stall%0d_iq_pc", k), 32'(iq_pc), 32'h1FFFC);
      end
      @(negedge clk);
      iq_full = 1'b0;
      #1;
      checkOutput("stall_release_push", 32'(iq_push), 32'd1);
      checkOutput("stall_release_rs_en", 32'(rs_en), 32'd1);
      checkOutput("stall_release_mode", 32'(rs_push_mode), 32'd1);
      checkOutput("stall_release_paddr", 32'(rs_push_addr), 32'h0);
      checkOutput("stall_release_taken", 32'(iq_pred_taken), 32'd1);
      checkOutput("stall_release_pred", 32'(iq_pred_pc), 32'h4);
      @(negedge clk);
      checkOutput("stall_next_addr", 32'(ic_req_addr), 32'h4);
      checkOutput("stall_next_valid", 32'(ic_req_valid), 32'd1);
      checkOutput("stall_next_push", 32'(iq_push), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
